// File: rtl/display_pkg.sv
// Default 640x480p60 timing values and a bundle type so other display modes can be added later.
package display_pkg;

    localparam int unsigned CORDW_480P  = 10;
    localparam int unsigned H_RES_480P  = 640;
    localparam int unsigned H_FP_480P   = 16;
    localparam int unsigned H_SYNC_480P = 96;
    localparam int unsigned H_BP_480P   = 48;
    localparam int unsigned V_RES_480P  = 480;
    localparam int unsigned V_FP_480P   = 10;
    localparam int unsigned V_SYNC_480P = 2;
    localparam int unsigned V_BP_480P   = 33;
    localparam bit          H_POL_480P  = 1'b0;
    localparam bit          V_POL_480P  = 1'b0;

    typedef struct packed {
        logic [15:0] h_res;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_res;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } display_timing_t;

    localparam display_timing_t TIMING_480P = '{
        h_res:  16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_res:  16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33
    };

    function automatic int unsigned axis_total(input int unsigned res, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return res + fp + sync + bp;
    endfunction

endpackage

// File: rtl/display_timings_480p_if.sv
// Pixel-coordinate and sync bundle from the timing generator to colour logic and VGA pins.
interface display_timings_480p_if
    import display_pkg::*;
#(
    parameter int unsigned CORDW = CORDW_480P
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             line;
    logic             frame;

    modport master (output sx, sy, hsync, vsync, de, line, frame);
    modport slave  (input  sx, sy, hsync, vsync, de, line, frame);
endinterface

// File: rtl/display_axis.sv
// One raster axis: wrapping position counter plus active/sync window flags of the next position.
module display_axis
    import display_pkg::*;
#(
    parameter int unsigned CORDW = CORDW_480P,
    parameter int unsigned RES   = H_RES_480P,
    parameter int unsigned FP    = H_FP_480P,
    parameter int unsigned SYNC  = H_SYNC_480P,
    parameter int unsigned BP    = H_BP_480P
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CORDW-1:0] pos_o,
    output logic             wrap_o,
    output logic             active_d_o,
    output logic             sync_d_o
);
    localparam int unsigned TOTAL = axis_total(RES, FP, SYNC, BP);

    if (TOTAL > (1 << CORDW)) begin : g_cordw_check
        $error("display_axis: CORDW too narrow for axis total");
    end

    localparam logic [CORDW-1:0] LAST     = CORDW'(TOTAL - 1);
    localparam logic [CORDW-1:0] ACT_END  = CORDW'(RES);
    localparam logic [CORDW-1:0] SYNC_ON  = CORDW'(RES + FP);
    localparam logic [CORDW-1:0] SYNC_OFF = CORDW'(RES + FP + SYNC);

    logic [CORDW-1:0] pos_d, pos_q;

    assign wrap_o = (pos_q == LAST);

    // Reset parks the counter on the last position so the first live cycle is position 0.
    always_comb begin
        pos_d = pos_q;
        if (rst_i) begin
            pos_d = LAST;
        end else if (en_i) begin
            pos_d = wrap_o ? '0 : pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        pos_q <= pos_d;
    end

    assign pos_o      = pos_q;
    assign active_d_o = (pos_d < ACT_END);
    assign sync_d_o   = (pos_d >= SYNC_ON) && (pos_d < SYNC_OFF);

endmodule

// File: rtl/display_timings_480p.sv
// Free-running 800x525 raster timing generator; every output describes the same pixel (sx,sy).
module display_timings_480p
    import display_pkg::*;
#(
    parameter int unsigned CORDW  = CORDW_480P,
    parameter int unsigned H_RES  = H_RES_480P,
    parameter int unsigned H_FP   = H_FP_480P,
    parameter int unsigned H_SYNC = H_SYNC_480P,
    parameter int unsigned H_BP   = H_BP_480P,
    parameter int unsigned V_RES  = V_RES_480P,
    parameter int unsigned V_FP   = V_FP_480P,
    parameter int unsigned V_SYNC = V_SYNC_480P,
    parameter int unsigned V_BP   = V_BP_480P,
    parameter bit          H_POL  = H_POL_480P,
    parameter bit          V_POL  = V_POL_480P
) (
    input  logic                   clk_pix,
    input  logic                   rst,
    display_timings_480p_if.master disp_if
);
    logic [CORDW-1:0] h_pos, v_pos;
    logic             h_wrap, v_wrap;
    logic             h_active_d, v_active_d;
    logic             h_sync_d, v_sync_d;

    display_axis #(
        .CORDW(CORDW), .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk_i      (clk_pix),
        .rst_i      (rst),
        .en_i       (1'b1),
        .pos_o      (h_pos),
        .wrap_o     (h_wrap),
        .active_d_o (h_active_d),
        .sync_d_o   (h_sync_d)
    );

    // Vertical steps only on the horizontal wrap, so vsync changes at line boundaries.
    display_axis #(
        .CORDW(CORDW), .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk_i      (clk_pix),
        .rst_i      (rst),
        .en_i       (h_wrap),
        .pos_o      (v_pos),
        .wrap_o     (v_wrap),
        .active_d_o (v_active_d),
        .sync_d_o   (v_sync_d)
    );

    logic de_q, line_q, frame_q, hsync_q, vsync_q;

    // A wrap this cycle means the next pixel sits at sx==0 (and sy==0 when both wrap).
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
        end else begin
            de_q    <= h_active_d && v_active_d;
            line_q  <= h_wrap;
            frame_q <= h_wrap && v_wrap;
            hsync_q <= h_sync_d ? H_POL : ~H_POL;
            vsync_q <= v_sync_d ? V_POL : ~V_POL;
        end
    end

    assign disp_if.sx    = h_pos;
    assign disp_if.sy    = v_pos;
    assign disp_if.de    = de_q;
    assign disp_if.line  = line_q;
    assign disp_if.frame = frame_q;
    assign disp_if.hsync = hsync_q;
    assign disp_if.vsync = vsync_q;

endmodule

// File: tb/tb_display_timings_480p.sv
// Directed bench: full 480p instance for line/wrap/reset, narrow-line instances for whole frames.
module tb_display_timings_480p;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    display_timings_480p_if #(.CORDW(10)) a_if ();
    display_timings_480p_if #(.CORDW(10)) s_if ();
    display_timings_480p_if #(.CORDW(10)) p_if ();

    display_timings_480p u_dut_a (
        .clk_pix (clk),
        .rst     (rst_a),
        .disp_if (a_if)
    );

    // Same vertical timing as 480p, 32-pixel lines (24 active, sync on 26..29) to keep frames short.
    display_timings_480p #(
        .H_RES(24), .H_FP(2), .H_SYNC(4), .H_BP(2)
    ) u_dut_s (
        .clk_pix (clk),
        .rst     (rst_b),
        .disp_if (s_if)
    );

    display_timings_480p #(
        .H_RES(24), .H_FP(2), .H_SYNC(4), .H_BP(2), .H_POL(1'b1), .V_POL(1'b1)
    ) u_dut_p (
        .clk_pix (clk),
        .rst     (rst_b),
        .disp_if (p_if)
    );

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_if.sx !== 10'd799) begin n_err++; $display("FAIL reset_sx: got %0d want 799", a_if.sx); end
        n_cmp++; if (a_if.sy !== 10'd524) begin n_err++; $display("FAIL reset_sy: got %0d want 524", a_if.sy); end
        n_cmp++; if (a_if.de !== 1'b0) begin n_err++; $display("FAIL reset_de: got %b want 0", a_if.de); end
        n_cmp++; if (a_if.hsync !== 1'b1) begin n_err++; $display("FAIL reset_hsync: got %b want 1", a_if.hsync); end
        n_cmp++; if (a_if.vsync !== 1'b1) begin n_err++; $display("FAIL reset_vsync: got %b want 1", a_if.vsync); end
        n_cmp++; if (a_if.line !== 1'b0) begin n_err++; $display("FAIL reset_line: got %b want 0", a_if.line); end
        n_cmp++; if (a_if.frame !== 1'b0) begin n_err++; $display("FAIL reset_frame: got %b want 0", a_if.frame); end
        n_cmp++; if (s_if.sx !== 10'd31) begin n_err++; $display("FAIL reset_small_sx: got %0d want 31", s_if.sx); end
        n_cmp++; if (p_if.hsync !== 1'b0) begin n_err++; $display("FAIL reset_pol_hsync: got %b want 0", p_if.hsync); end
        n_cmp++; if (p_if.vsync !== 1'b0) begin n_err++; $display("FAIL reset_pol_vsync: got %b want 0", p_if.vsync); end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_if.sx !== 10'd0) begin n_err++; $display("FAIL first_sx: got %0d want 0", a_if.sx); end
        n_cmp++; if (a_if.sy !== 10'd0) begin n_err++; $display("FAIL first_sy: got %0d want 0", a_if.sy); end
        n_cmp++; if (a_if.de !== 1'b1) begin n_err++; $display("FAIL first_de: got %b want 1", a_if.de); end
        n_cmp++; if (a_if.line !== 1'b1) begin n_err++; $display("FAIL first_line: got %b want 1", a_if.line); end
        n_cmp++; if (a_if.frame !== 1'b1) begin n_err++; $display("FAIL first_frame: got %b want 1", a_if.frame); end
        n_cmp++; if (a_if.hsync !== 1'b1) begin n_err++; $display("FAIL first_hsync: got %b want 1", a_if.hsync); end
    endtask

    // Starts on sx=0, sy=0 of the 480p instance.
    task automatic test_line();
        int de_cnt = 0, de_first_low = -1, hs_cnt = 0, hs_first = -1, hs_last = -1, line_cnt = 0;
        bit de_gap = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (a_if.de) begin
                de_cnt++;
                if (de_first_low >= 0) de_gap = 1'b1;
            end else if (de_first_low < 0) begin
                de_first_low = i;
            end
            if (!a_if.hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(a_if.sx);
                hs_last = int'(a_if.sx);
            end
            if (a_if.line) line_cnt++;
            @(negedge clk);
        end
        n_cmp++; if (de_cnt !== 640) begin n_err++; $display("FAIL line_de_count: got %0d want 640", de_cnt); end
        n_cmp++; if (de_first_low !== 640) begin n_err++; $display("FAIL line_de_end: got %0d want 640", de_first_low); end
        n_cmp++; if (de_gap !== 1'b0) begin n_err++; $display("FAIL line_de_contig: got %b want 0", de_gap); end
        n_cmp++; if (hs_cnt !== 96) begin n_err++; $display("FAIL line_hs_count: got %0d want 96", hs_cnt); end
        n_cmp++; if (hs_first !== 656) begin n_err++; $display("FAIL line_hs_start: got %0d want 656", hs_first); end
        n_cmp++; if (hs_last !== 751) begin n_err++; $display("FAIL line_hs_end: got %0d want 751", hs_last); end
        n_cmp++; if (line_cnt !== 1) begin n_err++; $display("FAIL line_strobes: got %0d want 1", line_cnt); end
        n_cmp++; if (a_if.line !== 1'b1) begin n_err++; $display("FAIL line_next: got %b want 1", a_if.line); end
        n_cmp++; if (a_if.sy !== 10'd1) begin n_err++; $display("FAIL line_next_sy: got %0d want 1", a_if.sy); end
    endtask

    task automatic test_wrap_mid();
        int n = 0;
        while (!(a_if.sx == 10'd799 && a_if.sy == 10'd10) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (n >= 10000) begin n_err++; $display("FAIL wrap_mid_reach: got timeout want sx=799 sy=10"); end
        n_cmp++; if (a_if.de !== 1'b0) begin n_err++; $display("FAIL wrap_mid_de: got %b want 0", a_if.de); end
        @(negedge clk);
        n_cmp++; if (a_if.sx !== 10'd0) begin n_err++; $display("FAIL wrap_mid_sx: got %0d want 0", a_if.sx); end
        n_cmp++; if (a_if.sy !== 10'd11) begin n_err++; $display("FAIL wrap_mid_sy: got %0d want 11", a_if.sy); end
        n_cmp++; if (a_if.frame !== 1'b0) begin n_err++; $display("FAIL wrap_mid_frame: got %b want 0", a_if.frame); end
        n_cmp++; if (a_if.line !== 1'b1) begin n_err++; $display("FAIL wrap_mid_line: got %b want 1", a_if.line); end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (!(a_if.sx == 10'd300 && a_if.sy == 10'd12) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (n >= 2000) begin n_err++; $display("FAIL midrst_reach: got timeout want sx=300 sy=12"); end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        n_cmp++; if (a_if.sx !== 10'd799) begin n_err++; $display("FAIL midrst_sx: got %0d want 799", a_if.sx); end
        n_cmp++; if (a_if.sy !== 10'd524) begin n_err++; $display("FAIL midrst_sy: got %0d want 524", a_if.sy); end
        n_cmp++; if (a_if.de !== 1'b0) begin n_err++; $display("FAIL midrst_de: got %b want 0", a_if.de); end
        n_cmp++; if (a_if.line !== 1'b0) begin n_err++; $display("FAIL midrst_line: got %b want 0", a_if.line); end
        @(negedge clk);
        n_cmp++; if (a_if.sx !== 10'd0) begin n_err++; $display("FAIL midrst_next_sx: got %0d want 0", a_if.sx); end
        n_cmp++; if (a_if.sy !== 10'd0) begin n_err++; $display("FAIL midrst_next_sy: got %0d want 0", a_if.sy); end
        n_cmp++; if (a_if.frame !== 1'b1) begin n_err++; $display("FAIL midrst_next_frame: got %b want 1", a_if.frame); end
    endtask

    // Whole frame on both narrow-line instances against a position model (32x525 raster).
    task automatic test_frame();
        int e_pos = 0, e_de = 0, e_hs = 0, e_vs = 0, e_line = 0, e_frame = 0, e_pol = 0;
        int line_cnt = 0, frame_cnt = 0, de_cnt = 0, vs_lo = 0, p_vs_hi = 0, p_hs_hi = 0;
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16800; i++) begin
            int   x, y;
            logic de_e, hs_act, vs_act, line_e, frame_e;
            x       = i % 32;
            y       = i / 32;
            de_e    = (x < 24) && (y < 480);
            hs_act  = (x >= 26) && (x < 30);
            vs_act  = (y >= 490) && (y < 492);
            line_e  = (x == 0);
            frame_e = (i == 0);
            if (s_if.sx !== 10'(x) || s_if.sy !== 10'(y)) e_pos++;
            if (s_if.de !== de_e) e_de++;
            if (s_if.hsync !== !hs_act) e_hs++;
            if (s_if.vsync !== !vs_act) e_vs++;
            if (s_if.line !== line_e) e_line++;
            if (s_if.frame !== frame_e) e_frame++;
            if (p_if.hsync !== hs_act || p_if.vsync !== vs_act || p_if.de !== de_e ||
                p_if.sx !== 10'(x) || p_if.sy !== 10'(y) || p_if.frame !== frame_e) e_pol++;
            if (s_if.line) line_cnt++;
            if (s_if.frame) frame_cnt++;
            if (s_if.de) de_cnt++;
            if (!s_if.vsync) vs_lo++;
            if (p_if.vsync) p_vs_hi++;
            if (p_if.hsync) p_hs_hi++;
            @(negedge clk);
        end
        n_cmp++; if (e_pos !== 0) begin n_err++; $display("FAIL frame_pos: got %0d bad cycles want 0", e_pos); end
        n_cmp++; if (e_de !== 0) begin n_err++; $display("FAIL frame_de: got %0d bad cycles want 0", e_de); end
        n_cmp++; if (e_hs !== 0) begin n_err++; $display("FAIL frame_hsync: got %0d bad cycles want 0", e_hs); end
        n_cmp++; if (e_vs !== 0) begin n_err++; $display("FAIL frame_vsync: got %0d bad cycles want 0", e_vs); end
        n_cmp++; if (e_line !== 0) begin n_err++; $display("FAIL frame_line: got %0d bad cycles want 0", e_line); end
        n_cmp++; if (e_frame !== 0) begin n_err++; $display("FAIL frame_frame: got %0d bad cycles want 0", e_frame); end
        n_cmp++; if (line_cnt !== 525) begin n_err++; $display("FAIL frame_lines: got %0d want 525", line_cnt); end
        n_cmp++; if (frame_cnt !== 1) begin n_err++; $display("FAIL frame_strobes: got %0d want 1", frame_cnt); end
        n_cmp++; if (de_cnt !== 11520) begin n_err++; $display("FAIL frame_de_count: got %0d want 11520", de_cnt); end
        n_cmp++; if (vs_lo !== 64) begin n_err++; $display("FAIL frame_vs_count: got %0d want 64", vs_lo); end
        n_cmp++; if (s_if.frame !== 1'b1) begin n_err++; $display("FAIL frame_period: got %b want 1", s_if.frame); end
        n_cmp++; if (e_pol !== 0) begin n_err++; $display("FAIL pol_model: got %0d bad cycles want 0", e_pol); end
        n_cmp++; if (p_vs_hi !== 64) begin n_err++; $display("FAIL pol_vs_count: got %0d want 64", p_vs_hi); end
        n_cmp++; if (p_hs_hi !== 2100) begin n_err++; $display("FAIL pol_hs_count: got %0d want 2100", p_hs_hi); end
    endtask

    task automatic test_wrap_frame();
        int n = 0;
        @(negedge clk);
        while (!(s_if.sx == 10'd31 && s_if.sy == 10'd524) && n < 17000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (n >= 17000) begin n_err++; $display("FAIL wrap_frame_reach: got timeout want sx=31 sy=524"); end
        n_cmp++; if (s_if.frame !== 1'b0) begin n_err++; $display("FAIL wrap_frame_pre: got %b want 0", s_if.frame); end
        @(negedge clk);
        n_cmp++; if (s_if.sx !== 10'd0) begin n_err++; $display("FAIL wrap_frame_sx: got %0d want 0", s_if.sx); end
        n_cmp++; if (s_if.sy !== 10'd0) begin n_err++; $display("FAIL wrap_frame_sy: got %0d want 0", s_if.sy); end
        n_cmp++; if (s_if.frame !== 1'b1) begin n_err++; $display("FAIL wrap_frame_frame: got %b want 1", s_if.frame); end
        n_cmp++; if (s_if.line !== 1'b1) begin n_err++; $display("FAIL wrap_frame_line: got %b want 1", s_if.line); end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        test_reset();
        test_line();
        test_wrap_mid();
        test_mid_reset();
        test_frame();
        test_wrap_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish before 5ms");
        $fatal(1);
    end
endmodule
